// File: rtl/inst_fetch.sv
// Instruction fetch stage: generates the fetch PC, issues one outstanding request on an
// SRAM-like instruction bus and pushes returned words, with their address, into the buffer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | reset state; leaves on the first edge after reset release
// REQ   | presenting a request at pc (suppressed while full or flushing)
// WAIT  | request accepted, read data pending
// HOLD  | returned word captured because the buffer was full
module inst_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              instBufferFull,
    output logic              we_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] iaddr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [ADDR_W-1:0]   req_pc, req_pc_nxt;
    logic [INST_W-1:0]   hold_inst, hold_inst_nxt;
    logic                discard, discard_nxt;
    logic                req_now;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            req_pc    <= '0;
            hold_inst <= '0;
            discard   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_pc    <= req_pc_nxt;
            hold_inst <= hold_inst_nxt;
            discard   <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_pc_nxt    = req_pc;
        hold_inst_nxt = hold_inst;
        discard_nxt   = discard;
        req_now       = 1'b0;
        we_o          = 1'b0;
        inst_o        = '0;
        iaddr_o       = '0;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end

            S_REQ: begin
                req_now = ~instBufferFull & ~flush;
                if (req_now && inst_addr_ok) begin
                    req_pc_nxt  = pc;
                    pc_nxt      = pc + ADDR_W'(4);
                    discard_nxt = 1'b0;
                    state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (inst_data_ok) begin
                    if (discard || flush) begin
                        state_nxt = S_REQ;
                    end else if (!instBufferFull) begin
                        we_o      = 1'b1;
                        inst_o    = inst_rdata;
                        iaddr_o   = req_pc;
                        state_nxt = S_REQ;
                    end else begin
                        hold_inst_nxt = inst_rdata;
                        state_nxt     = S_HOLD;
                    end
                end else if (flush) begin
                    // response still owed by the bus; remember to throw it away
                    discard_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    state_nxt = S_REQ;
                end else if (!instBufferFull) begin
                    we_o      = 1'b1;
                    inst_o    = hold_inst;
                    iaddr_o   = req_pc;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // a request is never accepted while flushing, so this cannot clash with pc+4
        if (flush && state != S_IDLE) begin
            pc_nxt = flush_pc;
        end
    end

    assign inst_req  = req_now;
    assign inst_addr = pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by randomized bus,
// full and flush traffic, all compared against a transaction-level fetch model.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        instBufferFull = 1'b0;
    logic        we_o;
    logic [31:0] inst_o;
    logic [31:0] iaddr_o;

    inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .instBufferFull (instBufferFull),
        .we_o           (we_o),
        .inst_o         (inst_o),
        .iaddr_o        (iaddr_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // fetch model: next fetch address, one outstanding bus read, one word awaiting the buffer
    bit          m_idle;
    logic [31:0] m_npc;
    bit          m_out;
    bit          m_oflush;
    logic [31:0] m_oaddr;
    bit          m_pend;
    logic [31:0] m_pdata;
    logic [31:0] m_paddr;
    int          bus_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0004) return 32'h2402_0001;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_npc   = RST_PC;
        m_out   = 1'b0;
        m_oflush = 1'b0;
        m_pend  = 1'b0;
        bus_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn         = 1'b0;
        flush          = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        instBufferFull = 1'b0;
        #1;
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_inst_addr", inst_addr, RST_PC);
        chk("rst_we_o", 32'(we_o), 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_iaddr_o", iaddr_o, 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic step(input bit fl, input logic [31:0] fpc, input bit aok,
                        input bit full, input bit dok);
        logic [31:0] rd;
        bit          e_req;
        bit          e_we;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
        @(negedge clk);
        rd = (m_out && dok) ? mem_word(m_oaddr) : $urandom;
        flush          = fl;
        flush_pc       = fpc;
        inst_addr_ok   = aok;
        instBufferFull = full;
        inst_data_ok   = dok;
        inst_rdata     = rd;

        e_req   = !m_idle && !m_out && !m_pend && !full && !fl;
        e_we    = 1'b0;
        e_inst  = '0;
        e_iaddr = '0;
        if (!m_idle) begin
            if (m_out && dok) begin
                m_out = 1'b0;
                if (!(m_oflush || fl)) begin
                    if (!full) begin
                        e_we = 1'b1; e_inst = rd; e_iaddr = m_oaddr;
                    end else begin
                        m_pend = 1'b1; m_pdata = rd; m_paddr = m_oaddr;
                    end
                end
            end else if (m_pend) begin
                if (fl) m_pend = 1'b0;
                else if (!full) begin
                    e_we = 1'b1; e_inst = m_pdata; e_iaddr = m_paddr; m_pend = 1'b0;
                end
            end else if (m_out && fl) begin
                m_oflush = 1'b1;
            end
        end

        #1;
        chk("inst_req", 32'(inst_req), 32'(e_req));
        chk("inst_addr", inst_addr, m_npc);
        chk("we_o", 32'(we_o), 32'(e_we));
        chk("inst_o", inst_o, e_inst);
        chk("iaddr_o", iaddr_o, e_iaddr);

        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            if (e_req && aok) begin
                m_out    = 1'b1;
                m_oflush = 1'b0;
                m_oaddr  = m_npc;
                m_npc    = m_npc + 32'd4;
                bus_cnt  = $urandom_range(0, 2);
            end
            if (fl) m_npc = fpc;
        end
    endtask

    task automatic rand_step();
        bit          fl;
        bit          dok;
        logic [31:0] r;
        r  = $urandom;
        fl = ($urandom_range(0, 11) == 0);
        if (m_out) begin
            dok = (bus_cnt == 0);
            if (bus_cnt != 0) bus_cnt--;
        end else begin
            dok = m_idle && ($urandom_range(0, 1) == 1);
        end
        step(fl, {r[31:2], 2'b00}, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), dok);
    endtask

    initial begin
        model_reset();
        do_reset();

        // free-running zero-wait bus, then full in REQ and release
        step(0, 0, 1, 0, 0);
        repeat (3) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // full as 0x24020001 @ BFC00004 returns, drop full three cycles later
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // flush in WAIT, late data dropped, refetch at 80000180
        step(0, 0, 1, 0, 0);
        step(1, 32'h8000_0180, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // flush in HOLD
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(1, 32'h8000_0200, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // flush coincident with data_ok, then PC wrap-around
        step(0, 0, 1, 0, 0);
        step(1, 32'hFFFF_FFFC, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // flush in REQ
        step(1, 32'h0000_1000, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // reset pulsed in WAIT, stray data_ok after release
        step(0, 0, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            rand_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of the dual-issue instruction buffer. It generates the fetch PC and drives an SRAM-like instruction bus with one outstanding request. Each returned word is pushed, with its address, into the buffer's write port. It stalls on buffer-full, holds one returned word when the buffer cannot accept it, and redirects on flush.

## Interface
- `ADDR_W`, default 32: PC and bus address width.
- `INST_W`, default 32: instruction width; must match the buffer's instruction bus.
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous reset, active-low.
- `flush`  in  1  redirect request; same-cycle flush as the buffer's flush.
- `flush_pc`  in  ADDR_W  redirect target, sampled when `flush`=1.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  ADDR_W  bus address; equals the current PC.
- `inst_addr_ok`  in  1  request accepted this cycle (valid only with `inst_req`).
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  INST_W  read data.
- `instBufferFull`  in  1  buffer full flag from the downstream buffer.
- `we_o`  out  1  buffer write enable.
- `inst_o`  out  INST_W  instruction to the buffer.
- `iaddr_o`  out  ADDR_W  address of `inst_o`.

## Operation
- State register values:
  - IDLE: reset state.
  - REQ: presenting a request.
  - WAIT: request accepted, data pending.
  - HOLD: data captured, buffer full.
- Other registers:
  - `pc`: resets to `RESET_PC`.
  - `req_pc`: address of the accepted request.
  - `hold_inst`: captured instruction.
  - `discard`: drop the pending response.
- IDLE → REQ unconditionally on the first edge after reset release.
- REQ:
  - `inst_req` = ~`instBufferFull` & ~`flush`, and `inst_addr` = `pc`.
  - A request is accepted when `inst_req` & `inst_addr_ok`. On acceptance: `req_pc` <= `pc`, `pc` <= `pc`+4, `discard` <= 0, state → WAIT.
  - The bus tolerates `inst_req` dropping before `addr_ok`. Only accepted cycles count as requests.
- WAIT, on `inst_data_ok`:
  - If `discard` or `flush`: drop the word, state → REQ.
  - Else if ~`instBufferFull`: `we_o`=1, `inst_o`=`inst_rdata`, `iaddr_o`=`req_pc` in that same cycle (combinational), state → REQ.
  - Else: `hold_inst` <= `inst_rdata`, state → HOLD.
- HOLD: `we_o` = ~`instBufferFull` & ~`flush`, `inst_o`=`hold_inst`, `iaddr_o`=`req_pc`. When `we_o`=1, state → REQ.
- `flush`, in any state except IDLE:
  - `pc` <= `flush_pc` and `we_o` is forced to 0.
  - REQ stays REQ.
  - WAIT without `data_ok` sets `discard` and stays WAIT.
  - WAIT with `data_ok` drops the word and goes to REQ.
  - HOLD drops `hold_inst` and goes to REQ.
  - The first request after a flush uses `flush_pc`.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- At most one accepted request is outstanding; there is never a new `inst_req` in WAIT or HOLD.
- Outputs while `resetn`=0:
  - `inst_req`=0, `we_o`=0, `inst_addr`=`RESET_PC`, `inst_o`=0, `iaddr_o`=0.
  - When `we_o`=0, `inst_o`/`iaddr_o` drive 0.
- Reset asserted mid-transaction returns to IDLE immediately. A late `data_ok` arriving after reset release, in IDLE/REQ, is ignored.

## Timing
- Zero-wait bus with `addr_ok` in the REQ cycle and `data_ok` on the next cycle: one instruction written every 2 cycles.
- Reset release to first `inst_req`=1: 1 edge (IDLE→REQ).
- `data_ok` to `we_o`: 0 cycles when not full.
- HOLD to write: same cycle `instBufferFull` falls.
- Flush to first request at `flush_pc`:
  - In REQ: the next cycle.
  - In WAIT: the cycle after the discarded `data_ok`.
- `instBufferFull` high blocks new requests but never blocks accepting `data_ok`; HOLD absorbs it.

## Test plan
- Reset then free-running bus (`addr_ok` in the REQ cycle, `data_ok` one cycle later) → `inst_addr` BFC00000, BFC00004, BFC00008. Writes carry the matching `iaddr_o` and `inst_rdata`, one every 2 cycles.
- `instBufferFull`=1 while in REQ → `inst_req`=0 and `pc` unchanged. Release → request at the same address.
- Full asserted as `data_ok` returns 0x24020001 @ BFC00004 → no write, HOLD. Full drops 3 cycles later → `we_o`=1 that cycle with 0x24020001/BFC00004.
- Flush with `flush_pc`=80000180 in WAIT; `data_ok` 2 cycles later → word dropped, `we_o` stays 0. Next request at 80000180.
- Flush in HOLD and flush coincident with `data_ok` → no write in either case; next request at `flush_pc`.
- `resetn` pulsed low while in WAIT → outputs immediately at reset values. A stray `data_ok` after release → no write; first request at BFC00000.
